// File: rtl/moore_pattern_tx.sv
// Moore-style serial pattern transmitter. It sends a captured WIDTH-bit pattern
// MSB-first repeat_n times, with GAP idle cycles between repetitions.
module moore_pattern_tx #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       fsm_state
);

  // Handshake: start is a request that is sampled only in IDLE. It is accepted
  // on that edge when repeat_n != 0 and is otherwise dropped, with no queuing.
  // valid qualifies out, one bit per cycle, and has no ready or back-pressure.
  localparam int BIT_W = $clog2(WIDTH);
  localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [CNT_W-1:0] ONE_REP  = CNT_W'(1);

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] pat_q;
  logic [CNT_W-1:0] reps;
  logic [BIT_W-1:0] bitcnt;
  logic [GAP_W-1:0] gapcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      shreg  <= '0;
      pat_q  <= '0;
      reps   <= '0;
      bitcnt <= '0;
      gapcnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && (repeat_n != '0)) begin
            shreg  <= pattern;
            pat_q  <= pattern;
            reps   <= repeat_n;
            bitcnt <= '0;
            state  <= S_SEND;
          end
        end
        S_SEND: begin
          shreg  <= {shreg[WIDTH-2:0], 1'b0};
          bitcnt <= bitcnt + 1'b1;
          if (bitcnt == LAST_BIT) begin
            reps <= reps - 1'b1;
            if (reps == ONE_REP) begin
              state <= S_DONE;
            end else if (GAP > 0) begin
              state  <= S_GAP;
              gapcnt <= '0;
            end else begin
              // Back-to-back repetition: reload in place and stay in SEND.
              shreg  <= pat_q;
              bitcnt <= '0;
            end
          end
        end
        S_GAP: begin
          if (gapcnt == LAST_GAP) begin
            shreg  <= pat_q;
            bitcnt <= '0;
            state  <= S_SEND;
          end else begin
            gapcnt <= gapcnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // All outputs are decoded from registered state only.
  always_comb begin
    out       = 1'b0;
    valid     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    fsm_state = state;
    case (state)
      S_SEND: begin
        out   = shreg[WIDTH-1];
        valid = 1'b1;
        busy  = 1'b1;
      end
      S_GAP:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_moore_pattern_tx.sv
// Directed bench for moore_pattern_tx. One instance has GAP=1 and the other has GAP=0.
// Each stream is checked cycle by cycle against hand-written vectors.
module tb_moore_pattern_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       g_start = 1'b0;
  logic [3:0] g_pattern = 4'b0000;
  logic [3:0] g_repeat_n = 4'd0;
  logic       g_out, g_valid, g_busy, g_done;
  logic [1:0] g_state;

  logic       b_start = 1'b0;
  logic [3:0] b_pattern = 4'b0000;
  logic [3:0] b_repeat_n = 4'd0;
  logic       b_out, b_valid, b_busy, b_done;
  logic [1:0] b_state;

  int n_cmp = 0;
  int n_bad = 0;

  // clock / reset
  always #5 clk = ~clk;

  moore_pattern_tx #(.WIDTH(4), .CNT_W(4), .GAP(1)) dut_g (
    .clk(clk), .rst(rst), .start(g_start), .pattern(g_pattern),
    .repeat_n(g_repeat_n), .out(g_out), .valid(g_valid), .busy(g_busy),
    .done(g_done), .fsm_state(g_state)
  );

  moore_pattern_tx #(.WIDTH(4), .CNT_W(4), .GAP(0)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .pattern(b_pattern),
    .repeat_n(b_repeat_n), .out(b_out), .valid(b_valid), .busy(b_busy),
    .done(b_done), .fsm_state(b_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Pulse start for one cycle. The task returns at the falling edge of the
  // cycle right after the accepting edge, which is the first bit cycle.
  task automatic launch(input bit sel, input logic [3:0] pat, input logic [3:0] rep);
    @(negedge clk);
    if (sel) begin
      b_pattern = pat; b_repeat_n = rep; b_start = 1'b1;
    end else begin
      g_pattern = pat; g_repeat_n = rep; g_start = 1'b1;
    end
    @(negedge clk);
    g_start = 1'b0;
    b_start = 1'b0;
  endtask

  // Check n cycles. The expected bit for cycle i is vector bit (n-1-i).
  // When poke is set, the task pulses start on dut_g during cycle 2 and
  // changes its pattern so that both can be seen to have no effect.
  task automatic expect_stream(input string name, input bit sel, input int n,
                               input logic [31:0] e_out, input logic [31:0] e_valid,
                               input logic [31:0] e_busy, input logic [31:0] e_done,
                               input bit poke);
    logic [3:0] saved_pat;
    saved_pat = g_pattern;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s[%0d].out", name, i),   {31'd0, sel ? b_out   : g_out},   {31'd0, e_out[n-1-i]});
      check($sformatf("%s[%0d].valid", name, i), {31'd0, sel ? b_valid : g_valid}, {31'd0, e_valid[n-1-i]});
      check($sformatf("%s[%0d].busy", name, i),  {31'd0, sel ? b_busy  : g_busy},  {31'd0, e_busy[n-1-i]});
      check($sformatf("%s[%0d].done", name, i),  {31'd0, sel ? b_done  : g_done},  {31'd0, e_done[n-1-i]});
      if (poke && i == 2) begin
        g_start = 1'b1; g_pattern = 4'b0100; g_repeat_n = 4'd1;
      end
      if (poke && i == 3) begin
        g_start = 1'b0; g_pattern = saved_pat;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    // reset state
    #2;
    check("reset.out", {31'd0, g_out}, 32'd0);
    check("reset.valid", {31'd0, g_valid}, 32'd0);
    check("reset.busy", {31'd0, g_busy}, 32'd0);
    check("reset.done", {31'd0, g_done}, 32'd0);
    check("reset.state", {30'd0, g_state}, 32'd0);
    check("reset.b_busy", {31'd0, b_busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single frame: 1011 sent once.
    launch(1'b0, 4'b1011, 4'd1);
    expect_stream("single", 1'b0, 6, 32'b101100, 32'b111100, 32'b111100, 32'b000010, 1'b0);

    // Three repeats with GAP=1. A start pulse and a pattern change arrive mid-SEND.
    launch(1'b0, 4'b1011, 4'd3);
    expect_stream("gap", 1'b0, 16,
                  32'b1011010110101100, 32'b1111011110111100,
                  32'b1111111111111100, 32'b0000000000000010, 1'b1);

    // Back-to-back with GAP=0: 1001 sent twice.
    launch(1'b1, 4'b1001, 4'd2);
    expect_stream("b2b", 1'b1, 10, 32'b1001100100, 32'b1111111100,
                  32'b1111111100, 32'b0000000010, 1'b0);

    // A start with repeat_n=0 is ignored.
    launch(1'b0, 4'b1111, 4'd0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rej0[%0d].busy", i), {31'd0, g_busy}, 32'd0);
      check($sformatf("rej0[%0d].valid", i), {31'd0, g_valid}, 32'd0);
      check($sformatf("rej0[%0d].state", i), {30'd0, g_state}, 32'd0);
      @(negedge clk);
    end

    // Asynchronous reset between edges while bit 2 of 1110 is on the line.
    launch(1'b0, 4'b1110, 4'd2);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("prerst.out", {31'd0, g_out}, 32'd1);
    rst = 1'b1;
    #1;
    check("asyncrst.out", {31'd0, g_out}, 32'd0);
    check("asyncrst.valid", {31'd0, g_valid}, 32'd0);
    check("asyncrst.busy", {31'd0, g_busy}, 32'd0);
    check("asyncrst.state", {30'd0, g_state}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("postrst.state", {30'd0, g_state}, 32'd0);
    check("postrst.busy", {31'd0, g_busy}, 32'd0);

    // A fresh frame after reset restarts from the MSB.
    launch(1'b0, 4'b1011, 4'd1);
    expect_stream("fresh", 1'b0, 6, 32'b101100, 32'b111100, 32'b111100, 32'b000010, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
